// File: rtl/popcnt_unit.sv
// popcnt_unit: multi-cycle population count, K bits per cycle, with start/busy/done handshake.
// Ports: clock, reset (sync, active-high), start, din[WIDTH] in; busy, done, count[CW], z out.
// Build option POPCNT_EARLY_EXIT_EN: leave RUN as soon as no set bits remain above the current chunk.
module popcnt_unit #(
    parameter int WIDTH = 32,
    parameter int K     = 4,
    parameter int CW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             z
);
    localparam int N   = WIDTH / K;
    localparam int CHW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CHW-1:0]   chunk_q;
    logic [CW-1:0]    acc_q, acc_d;
    logic             busy_q, done_q, last;

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < K; i++) acc_d = acc_d + CW'(shreg_q[i]);
    end

`ifdef POPCNT_EARLY_EXIT_EN
    assign last = (chunk_q == CHW'(N - 1)) || ((shreg_q >> K) == '0);
`else
    assign last = chunk_q == CHW'(N - 1);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            chunk_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q <= din;
                        acc_q   <= '0;
                        chunk_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q >> K;
                    chunk_q <= chunk_q + 1'b1;
                    if (last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = acc_q;
    assign z     = acc_q == '0;
endmodule

// File: tb/tb_popcnt_unit.sv
// tb_popcnt_unit: scoreboard bench for popcnt_unit (count, z and done latency).
module tb_popcnt_unit;
    localparam int W  = 32;
    localparam int K  = 4;
    localparam int CW = 6;
    localparam int N  = W / K;
`ifdef POPCNT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        int cnt;
        int due;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [W-1:0]  din = '0;
    logic          busy, done, z;
    logic [CW-1:0] count;
    int            tests = 0, errs = 0, cyc = 0;
    exp_t          sb[$];
    exp_t          mon_e;

    popcnt_unit #(.WIDTH(W), .K(K), .CW(CW)) dut (
        .clock(clk), .reset(reset), .start(start), .din(din),
        .busy(busy), .done(done), .count(count), .z(z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int got, input int want);
        tests++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end
    endtask

    function automatic int lat_of(input logic [W-1:0] d);
        int l = 1;
        if (!EE) return N;
        for (int i = 0; i < N; i++) if (d[i*K +: K] != '0) l = i + 1;
        return l;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            chk("busy_at_done", busy, 0);
            if (sb.size() == 0) chk("spurious_done", done, 0);
            else begin
                mon_e = sb.pop_front();
                chk("count", count, mon_e.cnt);
                chk("z", z, mon_e.cnt == 0);
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic issue(input logic [W-1:0] d, input int cnt, input int lat, input bit push);
        @(negedge clk);
        start = 1'b1;
        din   = d;
        @(negedge clk);
        start = 1'b0;
        din   = $urandom;
        if (push) sb.push_back('{cnt, cyc + lat});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !done) return;
        end
        tests++;
        errs++;
        $display("FAIL idle_timeout: busy=%0d pending=%0d want idle", busy, sb.size());
    endtask

    initial begin
        int bc;
        logic [W-1:0] d;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_z", z, 1);
        reset = 1'b0;

        issue(32'hFFFFFFFF, 32, N, 1'b1);
        bc = busy;
        repeat (N + 1) begin
            @(negedge clk);
            bc += busy;
        end
        chk("busy_cycles", bc, N);
        wait_idle();

        issue(32'h80000000, 1, N, 1'b1);
        wait_idle();
        issue(32'h0000000F, 4, EE ? 1 : N, 1'b1);
        wait_idle();
        issue(32'h00000000, 0, EE ? 1 : N, 1'b1);
        wait_idle();

        @(negedge clk);
        start = 1'b1;
        din   = 32'h0000FFFF;
        @(negedge clk);
        din = 32'hFFFFFFFF;
        sb.push_back('{16, cyc + (EE ? 4 : N)});
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        chk("hold_done_seen", done, 1);
        @(negedge clk);
        sb.push_back('{32, cyc + N});
        start = 1'b0;
        wait_idle();

        issue(32'hAAAAAAAA, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        chk("abort_z", z, 1);
        reset = 1'b0;
        repeat (N + 2) @(negedge clk);
        issue(32'hAAAAAAAA, 16, N, 1'b1);
        wait_idle();

        repeat (6) begin
            d = $urandom;
            issue(d, $countones(d), lat_of(d), 1'b1);
            wait_idle();
        end
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
